// File: rtl/eth_tap_pkg.sv
// eth_tap_pkg: shared tap word types, widths, scheduler states and the round-robin pick helper
package eth_tap_pkg;
  localparam int TAP_W        = 81;
  localparam int TAP_LAST_BIT = 80;
  localparam int SRC_W        = 2;
  typedef logic [TAP_W-1:0] tap_word_t;
  typedef struct packed {
    logic [SRC_W-1:0] src_id;
    tap_word_t        word;
  } out_word_t;
  typedef enum logic {ARB, XFER} sched_state_e;
  // First requesting source strictly after last, wrapping; last itself is checked last.
  function automatic logic [SRC_W-1:0] rr_pick(input logic [3:0] req, input logic [SRC_W-1:0] last, input int n);
    logic [SRC_W-1:0] c;
    rr_pick = last;
    for (int k = n; k >= 1; k--) begin
      c = SRC_W'((int'(last) + k) % n);
      if (req[c]) rr_pick = c;
    end
  endfunction
endpackage

// File: rtl/eth_tap_skid.sv
// eth_tap_skid: 2-entry (head + spare) output buffer in front of the encap FIFO
//   clk, rst_n    clock, asynchronous active-low reset
//   in_valid      word popped from a tap this cycle (only while spare is free)
//   in_data       {src_id, tap word}
//   out_full      encap FIFO full, sampled in the same cycle as the write
//   out_wr_en     encap FIFO write
//   out_din       head word, held while not written
//   head_valid    head entry occupied
//   spare_valid   spare entry occupied (upstream must not pop)
module eth_tap_skid #(
  parameter int W = eth_tap_pkg::SRC_W + eth_tap_pkg::TAP_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         out_full,
  output logic         out_wr_en,
  output logic [W-1:0] out_din,
  output logic         head_valid,
  output logic         spare_valid
);
  import eth_tap_pkg::*;
  logic         head_v_q, head_v_d, spare_v_q, spare_v_d, drain, load_head;
  logic [W-1:0] head_q, head_d, spare_q, spare_d;
  always_comb begin
    drain     = head_v_q && !out_full;
    load_head = !head_v_q || drain;
    head_v_d  = load_head ? (spare_v_q || in_valid) : 1'b1;
    head_d    = !load_head ? head_q : spare_v_q ? spare_q : in_valid ? in_data : head_q;
    spare_v_d = spare_v_q ? !drain : (in_valid && !load_head);
    spare_d   = (!spare_v_q && in_valid && !load_head) ? in_data : spare_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      head_v_q  <= 1'b0;
      spare_v_q <= 1'b0;
      head_q    <= '0;
      spare_q   <= '0;
    end else begin
      head_v_q  <= head_v_d;
      spare_v_q <= spare_v_d;
      head_q    <= head_d;
      spare_q   <= spare_d;
    end
  assign out_wr_en   = drain;
  assign out_din     = head_q;
  assign head_valid  = head_v_q;
  assign spare_valid = spare_v_q;
endmodule

// File: rtl/eth_tap_sched.sv
// eth_tap_sched: packet-atomic weighted round-robin drain of N_SRC tap FIFOs into one encap FIFO
//   clk, rst_n    clk156 clock, asynchronous active-low reset
//   src_empty     per-source FWFT empty
//   src_dout      per-source head word, source i at [i*IN_W +: IN_W], bit IN_W-1 = tlast
//   src_rd_en     per-source pop, one-hot or zero
//   out_full      encap FIFO full
//   out_wr_en     encap FIFO write
//   out_din       {src_id, tap word}
//   grant_id      current / last granted source
//   busy          transfer in progress or words buffered
//   ETH_TAP_SCHED_STATS_EN adds pkt_cnt (per-source packets) and stall_cnt (head blocked cycles)
module eth_tap_sched #(
  parameter int N_SRC  = 2,
  parameter int IN_W   = eth_tap_pkg::TAP_W,
  parameter int SRC_W  = eth_tap_pkg::SRC_W,
  parameter int WEIGHT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_SRC-1:0]      src_empty,
  input  logic [N_SRC*IN_W-1:0] src_dout,
  output logic [N_SRC-1:0]      src_rd_en,
  input  logic                  out_full,
  output logic                  out_wr_en,
  output logic [SRC_W+IN_W-1:0] out_din,
  output logic [SRC_W-1:0]      grant_id,
  output logic                  busy
`ifdef ETH_TAP_SCHED_STATS_EN
  ,
  output logic [N_SRC*32-1:0]   pkt_cnt,
  output logic [31:0]           stall_cnt
`endif
);
  import eth_tap_pkg::*;
  sched_state_e     state_q, state_d;
  logic [SRC_W-1:0] grant_q, grant_d;
  logic [3:0]       wcnt_q, wcnt_d, req;
  logic [IN_W-1:0]  words [4];
  logic             pop, pop_last, regrant, skid_head_v, skid_spare_v;
  // Sources are padded to four so a 2-bit grant always indexes in range.
  for (genvar i = 0; i < 4; i++) begin : g_src
    assign req[i]   = (i < N_SRC) && !src_empty[i % N_SRC];
    assign words[i] = src_dout[(i % N_SRC)*IN_W +: IN_W];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ARB;
      grant_q <= SRC_W'(N_SRC - 1);
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      wcnt_q  <= wcnt_d;
    end
  // grant_q doubles as the rr pointer: it only moves when the pointer would move.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    wcnt_d   = wcnt_q;
    regrant  = wcnt_q != '0 && req[grant_q];
    pop_last = pop && words[grant_q][IN_W-1];
    if (state_q == ARB && |req) begin
      grant_d = regrant ? grant_q : SRC_W'(rr_pick(req, 2'(grant_q), N_SRC));
      state_d = XFER;
      wcnt_d  = grant_d != grant_q ? '0 : wcnt_q;
    end else if (pop_last) begin
      state_d = ARB;
      wcnt_d  = wcnt_q + 4'd1 == 4'(WEIGHT) ? '0 : wcnt_q + 4'd1;
    end
  end
  always_comb begin
    pop       = state_q == XFER && req[grant_q] && !skid_spare_v;
    src_rd_en = pop ? N_SRC'(1) << grant_q : '0;
    busy      = state_q == XFER || skid_head_v || skid_spare_v;
    grant_id  = grant_q;
  end
  eth_tap_skid #(.W(SRC_W + IN_W)) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (pop),
    .in_data    ({grant_q, words[grant_q]}),
    .out_full   (out_full),
    .out_wr_en  (out_wr_en),
    .out_din    (out_din),
    .head_valid (skid_head_v),
    .spare_valid(skid_spare_v)
  );
`ifdef ETH_TAP_SCHED_STATS_EN
  logic [N_SRC*32-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [31:0]         stall_cnt_q, stall_cnt_d;
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (pop_last) pkt_cnt_d[32*int'(grant_q) +: 32] = pkt_cnt_q[32*int'(grant_q) +: 32] + 32'd1;
    stall_cnt_d = stall_cnt_q + 32'(skid_head_v && out_full);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pkt_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      pkt_cnt_q   <= pkt_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  assign pkt_cnt   = pkt_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_eth_tap_sched.sv
// tb_eth_tap_sched: directed and randomized checks of eth_tap_sched against a packet-level WRR model
module tb_eth_tap_sched;
  localparam int NS = 2, IW = 81, SW = 2, WT = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [NS-1:0] src_empty = '1, src_rd_en;
  logic [NS*IW-1:0] src_dout = '0;
  logic out_full = 1'b0, out_wr_en, busy;
  logic [SW+IW-1:0] out_din, prev_din;
  logic [SW-1:0] grant_id;
  logic [IW-1:0] fq [NS][$];
  bit first_q [NS][$];
  logic [SW+IW-1:0] exp_q [$];
  int gap [NS];
  int total = 0, bad = 0, cyc = 0, occ = 0, full_mode = 0, fw0 = 0, last_pop_cyc = -1;
  bit gaps_on = 0, strict = 1, last_pop_tl = 1, prev_stall = 0;

  eth_tap_sched #(.N_SRC(NS), .IN_W(IW), .SRC_W(SW), .WEIGHT(WT)) dut (
    .clk(clk), .rst_n(rst_n), .src_empty(src_empty), .src_dout(src_dout), .src_rd_en(src_rd_en),
    .out_full(out_full), .out_wr_en(out_wr_en), .out_din(out_din), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic add_pkt(input int s, input int len);
    logic [IW-1:0] w;
    for (int i = 0; i < len; i++) begin
      w = IW'({$urandom, $urandom, $urandom});
      w[IW-1] = (i == len - 1);
      fq[s].push_back(w);
      first_q[s].push_back(i == 0);
    end
  endtask

  // Packet-level WRR: keep the last source while its quota lasts, else next non-empty after it.
  task automatic model();
    logic [IW-1:0] mq [NS][$];
    logic [IW-1:0] w;
    int last, cnt, pick, left;
    last = NS - 1;
    cnt = 0;
    left = 0;
    for (int s = 0; s < NS; s++) begin
      mq[s] = fq[s];
      left += mq[s].size();
    end
    while (left > 0) begin
      pick = -1;
      if (cnt > 0 && mq[last].size() > 0) pick = last;
      for (int k = 1; k <= NS; k++)
        if (pick < 0 && mq[(last + k) % NS].size() > 0) pick = (last + k) % NS;
      if (pick != last) cnt = 0;
      do begin
        w = mq[pick].pop_front();
        left--;
        exp_q.push_back({SW'(pick), w});
      end while (!w[IW-1]);
      cnt++;
      if (cnt == WT) cnt = 0;
      last = pick;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int s = 0; s < NS; s++) begin
      fq[s].delete();
      first_q[s].delete();
      gap[s] = 0;
    end
    exp_q.delete();
    src_empty = '1;
    out_full = 1'b0;
    occ = 0;
    cyc = 0;
    prev_stall = 0;
    last_pop_cyc = -1;
    last_pop_tl = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", 128'(out_wr_en), 128'(0));
    chk("rst_rd_en", 128'(src_rd_en), 128'(0));
    chk("rst_din", 128'(out_din), 128'(0));
    chk("rst_grant", 128'(grant_id), 128'(NS - 1));
    chk("rst_busy", 128'(busy), 128'(0));
  endtask

  task automatic cycle();
    logic [NS-1:0] pops;
    logic [SW+IW-1:0] ew;
    logic wr;
    for (int s = 0; s < NS; s++) begin
      if (gap[s] > 0) gap[s]--;
      else if (gaps_on && fq[s].size() > 0 && !first_q[s][0] && $urandom_range(0, 4) == 0) gap[s] = $urandom_range(1, 4);
      src_empty[s] = fq[s].size() == 0 || gap[s] > 0;
      src_dout[s*IW +: IW] = fq[s].size() > 0 ? fq[s][0] : IW'({$urandom, $urandom, $urandom});
    end
    out_full = full_mode == 1 ? ($urandom_range(0, 2) == 0) : full_mode == 2 ? (cyc >= fw0 && cyc < fw0 + 5) : 1'b0;
    #4;
    pops = src_rd_en;
    wr = out_wr_en;
    chk("wr_en", 128'(wr), 128'(occ > 0 && !out_full));
    chk("occ_le2", 128'(occ <= 2), 128'(1));
    if (prev_stall) chk("din_stable", 128'(out_din), 128'(prev_din));
    if (wr) begin
      ew = 'x;
      if (exp_q.size() > 0) ew = exp_q.pop_front();
      chk("out_word", 128'(out_din), 128'(ew));
    end
    chk("rd_onehot0", 128'($onehot0(pops)), 128'(1));
    for (int s = 0; s < NS; s++) begin
      if (fq[s].size() > 0 && !first_q[s][0]) chk("busy_inflight", 128'(busy), 128'(1));
      if (pops[s]) begin
        chk("rd_not_empty", 128'(src_empty[s]), 128'(0));
        chk("rd_grant", 128'(grant_id), 128'(s));
        if (strict) chk("pop_gap", 128'(cyc - last_pop_cyc), 128'(last_pop_tl ? 2 : 1));
        last_pop_cyc = cyc;
        last_pop_tl = fq[s].size() > 0 ? fq[s][0][IW-1] : 1'b0;
      end
    end
    if (occ > 0) chk("busy_skid", 128'(busy), 128'(1));
    prev_stall = occ > 0 && !wr;
    prev_din = out_din;
    @(posedge clk);
    #1;
    for (int s = 0; s < NS; s++)
      if (pops[s] && fq[s].size() > 0) begin
        void'(fq[s].pop_front());
        void'(first_q[s].pop_front());
      end
    occ = occ + int'(|pops) - int'(wr);
    cyc++;
  endtask

  task automatic run(input int maxc);
    for (int n = 0; n < maxc && (exp_q.size() > 0 || occ > 0); n++) cycle();
    chk("drained", 128'(exp_q.size()), 128'(0));
    repeat (2) cycle();
    chk("idle_busy", 128'(busy), 128'(0));
    chk("idle_rd", 128'(src_rd_en), 128'(0));
  endtask

  initial begin
    // single 3-word packet from src0
    do_reset();
    add_pkt(0, 3);
    model();
    rst_n = 1'b1;
    run(40);
    // both sources with two 2-word packets each
    do_reset();
    add_pkt(0, 2); add_pkt(0, 2); add_pkt(1, 2); add_pkt(1, 2);
    model();
    rst_n = 1'b1;
    run(60);
    // weight: src0 holds 4 packets, src1 holds 1
    do_reset();
    repeat (4) add_pkt(0, 2);
    add_pkt(1, 3);
    model();
    rst_n = 1'b1;
    run(80);
    // out_full held for 5 cycles mid-packet
    strict = 0;
    do_reset();
    add_pkt(0, 8); add_pkt(1, 2);
    full_mode = 2;
    fw0 = 4;
    model();
    rst_n = 1'b1;
    run(80);
    full_mode = 0;
    // src0 empties mid-packet for 10 cycles while src1 waits
    do_reset();
    add_pkt(0, 4); add_pkt(1, 2);
    model();
    rst_n = 1'b1;
    for (int i = 0; i < 10 && fq[0].size() != 3; i++) cycle();
    gap[0] = 11;
    run(80);
    // asynchronous reset mid-packet, then src0 served first
    strict = 1;
    do_reset();
    add_pkt(0, 4); add_pkt(1, 2);
    model();
    rst_n = 1'b1;
    repeat (3) cycle();
    chk("pre_arst_busy", 128'(busy), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wr_en", 128'(out_wr_en), 128'(0));
    chk("arst_rd_en", 128'(src_rd_en), 128'(0));
    chk("arst_din", 128'(out_din), 128'(0));
    chk("arst_busy", 128'(busy), 128'(0));
    chk("arst_grant", 128'(grant_id), 128'(NS - 1));
    do_reset();
    add_pkt(1, 2); add_pkt(0, 2);
    model();
    rst_n = 1'b1;
    run(40);
    // randomized traffic, backpressure and mid-packet gaps
    strict = 0;
    gaps_on = 1;
    for (int r = 0; r < 20; r++) begin
      do_reset();
      full_mode = 1;
      for (int s = 0; s < NS; s++) repeat ($urandom_range(0, 4)) add_pkt(s, $urandom_range(1, 5));
      model();
      rst_n = 1'b1;
      run(2000);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
